// File: rtl/calc_sched.sv
// Calculation scheduler: serially loads a 12-bit coefficient into an external
// datapath, then feeds it round-robin operands under a credit limit and queues results.
module calc_sched #(
    parameter int LAT    = 10,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] cfg_d,
    input  logic        cfg_start,
    output logic        cfg_busy,
    output logic        dp_rst,
    output logic        dp_e,
    output logic [11:0] dp_a,
    output logic [11:0] dp_b,
    output logic [11:0] dp_c,
    input  logic [12:0] dp_y,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [35:0] req0_data,
    input  logic [35:0] req1_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [12:0] out_data,
    output logic        out_id
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int NW = 16;

    typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_LOAD, S_SETTLE, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   cnt_q, cnt_d;
    logic [11:0]     d_q, d_d;
    logic            ptr_q, ptr_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [LAT-1:0]  sh_vld_q, sh_vld_d;
    logic [LAT-1:0]  sh_id_q, sh_id_d;
    logic [13:0]     mem_q [DEPTH];
    logic [13:0]     mem_d [DEPTH];
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   fcnt_q, fcnt_d;

    logic            credit_ok, gnt_id, issue, push, pop, tail_vld, tail_id;
    logic [35:0]     gnt_data;
    logic [3:0]      bit_idx;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Sequencer: LOAD spends cnt 0 on dp_rst and cnt 1..12 on the d bits.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    d_d     = cfg_d;
                end
            end
            S_RUN: begin
                if (cfg_start) begin
                    state_d = S_DRAIN;
                    d_d     = cfg_d;
                end
            end
            S_DRAIN: begin
                if (inflight_q == '0) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (cnt_q == NW'(12)) begin
                    cnt_d   = '0;
                    state_d = (SETTLE == 0) ? S_RUN : S_SETTLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == NW'(SETTLE - 1)) begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bit_idx  = cnt_q[3:0] - 4'd1;
        dp_rst   = rst || (state_q == S_LOAD && cnt_q == '0);
        dp_e     = (state_q == S_LOAD && cnt_q != '0) ? d_q[bit_idx] : 1'b0;
        cfg_busy = (state_q != S_RUN);
    end

    // Credit counts results both in flight and already queued.
    always_comb begin
        credit_ok  = ({1'b0, inflight_q} + {1'b0, fcnt_q}) < (CW + 1)'(DEPTH);
        gnt_id     = (req0_valid && req1_valid) ? ptr_q : req1_valid;
        issue      = (state_q == S_RUN) && credit_ok && (req0_valid || req1_valid);
        gnt_data   = gnt_id ? req1_data : req0_data;
        req0_ready = issue && !gnt_id;
        req1_ready = issue && gnt_id;
        dp_a       = issue ? gnt_data[35:24] : '0;
        dp_b       = issue ? gnt_data[23:12] : '0;
        dp_c       = issue ? gnt_data[11:0]  : '0;
        ptr_d      = issue ? ~gnt_id : ptr_q;
    end

    always_comb begin
        tail_vld    = sh_vld_q[LAT-1];
        tail_id     = sh_id_q[LAT-1];
        sh_vld_d    = '0;
        sh_id_d     = '0;
        sh_vld_d[0] = issue;
        sh_id_d[0]  = gnt_id;
        for (int i = 1; i < LAT; i++) begin
            sh_vld_d[i] = sh_vld_q[i-1];
            sh_id_d[i]  = sh_id_q[i-1];
        end
        inflight_d = inflight_q;
        if (issue && !tail_vld) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!issue && tail_vld) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    // Result FIFO: the head is read before the edge, so push+pop when full is safe.
    always_comb begin
        push      = tail_vld;
        out_valid = (fcnt_q != '0);
        pop       = out_valid && out_ready;
        mem_d     = mem_q;
        if (push) begin
            mem_d[wr_q] = {dp_y, tail_id};
        end
        wr_d   = push ? ptr_inc(wr_q) : wr_q;
        rd_d   = pop ? ptr_inc(rd_q) : rd_q;
        fcnt_d = fcnt_q;
        if (push && !pop) begin
            fcnt_d = fcnt_q + 1'b1;
        end else if (!push && pop) begin
            fcnt_d = fcnt_q - 1'b1;
        end
        out_data = out_valid ? mem_q[rd_q][13:1] : '0;
        out_id   = out_valid ? mem_q[rd_q][0] : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            d_q        <= '0;
            ptr_q      <= 1'b0;
            inflight_q <= '0;
            sh_vld_q   <= '0;
            sh_id_q    <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            d_q        <= d_d;
            ptr_q      <= ptr_d;
            inflight_q <= inflight_d;
            sh_vld_q   <= sh_vld_d;
            sh_id_q    <= sh_id_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            fcnt_q     <= fcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && fcnt_q == CW'(DEPTH)));

endmodule
